// File: rtl/nn_mem_pkg.sv
// Shared widths, default depth and store-entry layout for the store buffer.
package nn_mem_pkg;

    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Load-address match over the valid store entries; the youngest matching entry wins.
module store_buffer_match #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0] entry_addr [DEPTH],
    input  logic [PTR_WIDTH-1:0]  rd_ptr,
    input  logic [PTR_WIDTH:0]    count,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  hit,
    output logic [PTR_WIDTH-1:0]  hit_idx
);

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_WIDTH-1:0] idx;
        hit     = 1'b0;
        hit_idx = rd_ptr;
        idx     = rd_ptr;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_WIDTH'(k);
            if ((k < 32'(count)) && (entry_addr[idx] == ld_addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer draining to data memory; load forwarding enabled by STORE_BUF_FWD_EN,
// otherwise matching loads are stalled via ldWait.
module store_buffer #(
    parameter int unsigned DEPTH      = nn_mem_pkg::DEPTH_DEFAULT,
    parameter int unsigned ADDR_WIDTH = nn_mem_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = nn_mem_pkg::DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  stReq,
    input  logic [ADDR_WIDTH-1:0] stAddr,
    input  logic [DATA_WIDTH-1:0] stData,
    output logic                  stallOut,
    input  logic                  ldReq,
    input  logic [ADDR_WIDTH-1:0] ldAddr,
    input  logic [DATA_WIDTH-1:0] memReadData,
    output logic [DATA_WIDTH-1:0] ldData,
    output logic                  ldHit,
    output logic                  ldWait,
    input  logic                  drainBlock,
    output logic                  memWriteEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  empty
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                entries    [DEPTH];
    logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH:0]    count;
    logic                  push;
    logic                  pop;
    logic                  match_hit;
    logic [PTR_WIDTH-1:0]  match_idx;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_addr[i] = entries[i].addr;
        end
    end

    assign stallOut     = (count == (PTR_WIDTH+1)'(DEPTH));
    assign empty        = (count == '0);
    assign memWriteEn   = (count != '0) && !drainBlock;
    assign memAddr      = entries[rd_ptr].addr;
    assign memWriteData = entries[rd_ptr].data;

    // A full buffer refuses the store even when the head drains this same cycle.
    assign push = stReq && !stallOut;
    assign pop  = memWriteEn;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            if (push && !pop)      count <= count + (PTR_WIDTH+1)'(1);
            else if (pop && !push) count <= count - (PTR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) entries[wr_ptr] <= '{addr: stAddr, data: stData};
    end

    store_buffer_match #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_match (
        .entry_addr (entry_addr),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .ld_addr    (ldAddr),
        .hit        (match_hit),
        .hit_idx    (match_idx)
    );

`ifdef STORE_BUF_FWD_EN
    assign ldHit  = ldReq && match_hit;
    assign ldData = ldHit ? entries[match_idx].data : memReadData;
    assign ldWait = 1'b0;
`else
    logic unused_match_idx;
    assign unused_match_idx = ^match_idx;
    assign ldHit  = 1'b0;
    assign ldData = memReadData;
    assign ldWait = ldReq && match_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus directed scenarios.
module tb_store_buffer;
    import nn_mem_pkg::*;

    localparam int unsigned D = DEPTH_DEFAULT;

    logic                  CLK = 1'b0;
    logic                  RSTn;
    logic                  stReq;
    logic [ADDR_WIDTH-1:0] stAddr;
    logic [DATA_WIDTH-1:0] stData;
    logic                  stallOut;
    logic                  ldReq;
    logic [ADDR_WIDTH-1:0] ldAddr;
    logic [DATA_WIDTH-1:0] memReadData;
    logic [DATA_WIDTH-1:0] ldData;
    logic                  ldHit;
    logic                  ldWait;
    logic                  drainBlock;
    logic                  memWriteEn;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic                  empty;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;
    assign memReadData = ldAddr ^ 32'hA5A5_0000;

    store_buffer #(
        .DEPTH      (D),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .stReq        (stReq),
        .stAddr       (stAddr),
        .stData       (stData),
        .stallOut     (stallOut),
        .ldReq        (ldReq),
        .ldAddr       (ldAddr),
        .memReadData  (memReadData),
        .ldData       (ldData),
        .ldHit        (ldHit),
        .ldWait       (ldWait),
        .drainBlock   (drainBlock),
        .memWriteEn   (memWriteEn),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .empty        (empty)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending stores in acceptance order, oldest at index 0.
    sb_entry_t             q[$];
    logic [ADDR_WIDTH-1:0] wlog[$];
    bit                    armed = 1'b0;

    always @(negedge CLK) begin
        bit                    e_we, e_stall, found;
        logic [DATA_WIDTH-1:0] fdata;
        e_stall = (q.size() == D);
        e_we    = (q.size() > 0) && !drainBlock;
        found   = 1'b0;
        fdata   = '0;
        foreach (q[i]) if (q[i].addr == ldAddr) begin found = 1'b1; fdata = q[i].data; end
        if (armed) begin
            chk("stallOut", stallOut, e_stall);
            chk("empty", empty, q.size() == 0);
            chk("memWriteEn", memWriteEn, e_we);
            if (e_we) begin
                chk("memAddr", memAddr, q[0].addr);
                chk("memWriteData", memWriteData, q[0].data);
            end
`ifdef STORE_BUF_FWD_EN
            chk("ldHit", ldHit, ldReq && found);
            chk("ldData", ldData, (ldReq && found) ? fdata : memReadData);
            chk("ldWait", ldWait, 1'b0);
`else
            chk("ldHit", ldHit, 1'b0);
            chk("ldData", ldData, memReadData);
            chk("ldWait", ldWait, ldReq && found);
`endif
            if (memWriteEn && RSTn) wlog.push_back(memAddr);
        end
        if (!RSTn) begin
            q.delete();
            armed = 1'b1;
        end else begin
            if (e_we) void'(q.pop_front());
            if (stReq && !e_stall) q.push_back('{addr: stAddr, data: stData});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic peek();
        @(negedge CLK);
        #1;
    endtask

    task automatic store(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        stReq = 1'b1; stAddr = a; stData = d;
        step();
        stReq = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 20 && !empty; i++) step();
        chk(nm, empty, 1'b1);
    endtask

    initial begin
        logic [ADDR_WIDTH-1:0] exp34 [5];
        logic [ADDR_WIDTH-1:0] cur_a;
        exp34 = '{32'h100, 32'h104, 32'h108, 32'h10c, 32'h200};

        RSTn = 1'b0; stReq = 1'b0; stAddr = '0; stData = '0;
        ldReq = 1'b0; ldAddr = '0; drainBlock = 1'b0;
        @(posedge CLK); #1;
        step();
        peek();
        chk("rst_empty", empty, 1'b1);
        chk("rst_stall", stallOut, 1'b0);
        chk("rst_we", memWriteEn, 1'b0);
        chk("rst_ldhit", ldHit, 1'b0);
        chk("rst_ldwait", ldWait, 1'b0);
        step();
        RSTn = 1'b1;

        // Single store reaches memory one cycle after acceptance.
        store(32'h10, 32'hAAAA);
        peek();
        chk("s1_we", memWriteEn, 1'b1);
        chk("s1_addr", memAddr, 32'h10);
        chk("s1_data", memWriteData, 32'hAAAA);
        step();
        peek();
        chk("s1_empty", empty, 1'b1);
        step();

        // Fill, stall a fifth store, then release the drain.
        drainBlock = 1'b1;
        for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
        stReq = 1'b1; stAddr = 32'h200; stData = 32'h5;
        peek();
        chk("s2_stall", stallOut, 1'b1);
        step();
        peek();
        chk("s2_held", stallOut, 1'b1);
        step();
        wlog.delete();
        drainBlock = 1'b0;
        peek();
        chk("s2_stall_on_drain", stallOut, 1'b1);
        step();
        peek();
        chk("s2_accept", stallOut, 1'b0);
        step();
        stReq = 1'b0;
        wait_empty("s2_drained");
        step();
        chk("s2_wr_count", wlog.size(), 5);
        for (int i = 0; i < 5; i++) if (i < wlog.size()) chk("s2_order", wlog[i], exp34[i]);

`ifdef STORE_BUF_FWD_EN
        // Youngest duplicate forwards; a non-matching load reads memory.
        drainBlock = 1'b1;
        store(32'h20, 32'h1);
        store(32'h20, 32'h2);
        ldReq = 1'b1; ldAddr = 32'h20;
        peek();
        chk("fwd_data", ldData, 32'h2);
        chk("fwd_hit", ldHit, 1'b1);
        step();
        ldAddr = 32'h24;
        peek();
        chk("fwd_miss_data", ldData, 32'hA5A5_0024);
        chk("fwd_miss_hit", ldHit, 1'b0);
        step();
        ldReq = 1'b0; drainBlock = 1'b0;
        wait_empty("fwd_drained");
`else
        // Load waits while the matching store is pending, including while it is the head draining.
        drainBlock = 1'b1;
        store(32'h30, 32'h7);
        store(32'h34, 32'h8);
        ldReq = 1'b1; ldAddr = 32'h30;
        peek();
        chk("wait_pending", ldWait, 1'b1);
        step();
        drainBlock = 1'b0;
        peek();
        chk("wait_head_drain", ldWait, 1'b1);
        step();
        peek();
        chk("wait_released", ldWait, 1'b0);
        chk("wait_data", ldData, 32'hA5A5_0030);
        step();
        ldReq = 1'b0;
        wait_empty("wait_drained");
`endif

        // Full buffer, three cycles of store pressure across pointer wrap, reset mid-drain.
        drainBlock = 1'b1;
        for (int i = 0; i < 4; i++) store(32'h300 + 32'(i), 32'h3000 + 32'(i));
        wlog.delete();
        drainBlock = 1'b0;
        cur_a = 32'h400;
        for (int c = 0; c < 3; c++) begin
            stReq = 1'b1; stAddr = cur_a; stData = 32'h4000 + cur_a;
            peek();
            if (!stallOut) cur_a = cur_a + 32'h1;
            step();
        end
        stReq = 1'b0;
        chk("wrap_accepted", cur_a, 32'h402);
        step();
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        peek();
        chk("wrap_rst_we", memWriteEn, 1'b0);
        chk("wrap_rst_empty", empty, 1'b1);
        chk("wrap_wr_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) if (i < wlog.size()) chk("wrap_order", wlog[i], 32'h300 + 32'(i));
        step();

        // Random traffic over a small address set to provoke duplicates and matches.
        for (int n = 0; n < 400; n++) begin
            stReq      = ($urandom_range(0, 99) < 60);
            stAddr     = 32'h40 + 32'(4 * $urandom_range(0, 3));
            stData     = $urandom;
            ldReq      = ($urandom_range(0, 99) < 50);
            ldAddr     = 32'h40 + 32'(4 * $urandom_range(0, 4));
            drainBlock = ($urandom_range(0, 99) < 40);
            RSTn       = ($urandom_range(0, 99) >= 2);
            step();
        end
        RSTn = 1'b1; stReq = 1'b0; ldReq = 1'b0; drainBlock = 1'b0;
        wait_empty("final_drained");
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
